// File: rtl/multi_lane_target_pc_checker_if.sv
// Commit-stream and error-log bundle between a core's retire port and the
// control-flow checker.
interface multi_lane_target_pc_checker_if #(
    parameter int NUM_LANES = 2,
    parameter int CNT_W     = 16
);
    localparam int LW = $clog2(NUM_LANES) + 1;

    logic [NUM_LANES-1:0]    commit;
    logic [32*NUM_LANES-1:0] pc_rdata;
    logic [32*NUM_LANES-1:0] inst;
    logic [32*NUM_LANES-1:0] rs1_rdata;
    logic [32*NUM_LANES-1:0] rs2_rdata;
    logic                    err_detect;
    logic [CNT_W-1:0]        err_count;
    logic                    log_valid;
    logic                    log_ready;
    logic [31:0]             log_exp_pc;
    logic [31:0]             log_got_pc;
    logic [LW-1:0]           log_lane;
    logic                    log_overflow;

    modport master (
        output commit, pc_rdata, inst, rs1_rdata, rs2_rdata, log_ready,
        input  err_detect, err_count, log_valid, log_exp_pc, log_got_pc,
        input  log_lane, log_overflow
    );

    modport slave (
        input  commit, pc_rdata, inst, rs1_rdata, rs2_rdata, log_ready,
        output err_detect, err_count, log_valid, log_exp_pc, log_got_pc,
        output log_lane, log_overflow
    );
endinterface

// File: rtl/multi_lane_target_pc_checker.sv
// Registered N-wide commit-stream control-flow checker: predicts each lane's
// PC from the previous committed lane and logs mismatches into a small FIFO.
module multi_lane_target_pc_checker #(
    parameter int          NUM_LANES = 2,
    parameter logic [31:0] RESET_PC  = 32'h60,
    parameter int          IALIGN    = 32,
    parameter int          CNT_W     = 16,
    parameter int          LOG_DEPTH = 4
) (
    input logic                           clk,
    input logic                           rst,
    multi_lane_target_pc_checker_if.slave bus
);
    localparam int LW = $clog2(NUM_LANES) + 1;
    localparam int AW = $clog2(LOG_DEPTH);

    typedef struct packed {
        logic [31:0]   exp_pc;
        logic [31:0]   got_pc;
        logic [LW-1:0] lane;
    } rec_t;

    function automatic logic [31:0] next_pc(
        input  logic [31:0] pc,
        input  logic [31:0] ins,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic        bad
    );
        logic [31:0] ft;
        logic [31:0] j_imm;
        logic [31:0] i_imm;
        logic [31:0] b_imm;
        logic [31:0] tgt;
        logic        taken;
        logic        is_jal;
        logic        is_jalr;
        logic        is_br;
        ft    = (IALIGN == 32 || ins[1:0] == 2'b11) ? pc + 32'd4 : pc + 32'd2;
        j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        i_imm = {{20{ins[31]}}, ins[31:20]};
        b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        is_jal  = (ins[6:0] == 7'b1101111);
        is_jalr = (ins[6:0] == 7'b1100111);
        is_br   = (ins[6:0] == 7'b1100011);
        taken = 1'b0;
        bad   = 1'b0;
        case (ins[14:12])
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) < $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a < b);
            3'b111:  taken = (a >= b);
            default: bad   = is_br;
        endcase
        tgt    = a + i_imm;
        tgt[0] = 1'b0;
        if (IALIGN == 32) tgt[1] = 1'b0;
        unique case (1'b1)
            is_jal:  next_pc = pc + j_imm;
            is_jalr: next_pc = tgt;
            is_br:   next_pc = taken ? pc + b_imm : ft;
            default: next_pc = ft;
        endcase
    endfunction

    logic [31:0]          exp_pc_q, exp_pc_d;
    logic                 det_q, det_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 hv_q, hv_d;
    rec_t                 head_q, head_d;
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    rec_t                 mem_q [LOG_DEPTH];

    logic [31:0]          e [NUM_LANES+1];
    logic [NUM_LANES-1:0] lane_ok, mis, badf;
    logic                 live, nb, gap;
    logic [LW-1:0]        pop_n;
    logic [CNT_W:0]       cnt_sum;
    rec_t                 rec_new;
    logic                 empty, full, pop, push;

    // Prediction chain: each lane's successor comes from its own committed PC.
    always_comb begin
        live     = 1'b1;
        nb       = 1'b0;
        e[0]     = exp_pc_q;
        exp_pc_d = exp_pc_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_ok[i] = live & bus.commit[i];
            live       = lane_ok[i];
            e[i+1]     = next_pc(bus.pc_rdata[32*i+:32], bus.inst[32*i+:32],
                                 bus.rs1_rdata[32*i+:32], bus.rs2_rdata[32*i+:32], nb);
            badf[i]    = lane_ok[i] & nb;
            mis[i]     = lane_ok[i] & (bus.pc_rdata[32*i+:32] != e[i]);
            if (lane_ok[i]) exp_pc_d = e[i+1];
        end
        gap = |(bus.commit & ~lane_ok);
    end

    always_comb begin
        pop_n   = '0;
        rec_new = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            pop_n = pop_n + LW'(mis[i]);
            if (mis[i]) begin
                rec_new.exp_pc = e[i];
                rec_new.got_pc = bus.pc_rdata[32*i+:32];
                rec_new.lane   = LW'(i);
            end
        end
        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(pop_n);
        cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        det_d   = det_q | (|mis) | (|badf) | gap;
    end

    assign empty = (wr_q == rd_q);
    assign full  = ((wr_q - rd_q) == (AW+1)'(LOG_DEPTH));
    assign pop   = bus.log_ready & ~empty;
    assign push  = (|mis) & (~full | pop);
    assign rd_d  = rd_q + (AW+1)'(pop);
    assign wr_d  = wr_q + (AW+1)'(push);
    assign ovf_d = ovf_q | ((|mis) & full & ~pop);
    assign hv_d  = (wr_d != rd_d);

    // A record pushed into an empty slot at the new head bypasses the memory.
    always_comb begin
        if (push && rd_d == wr_q) head_d = rec_new;
        else                      head_d = mem_q[rd_d[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_pc_q <= RESET_PC;
            det_q    <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            hv_q     <= 1'b0;
            head_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            exp_pc_q <= exp_pc_d;
            det_q    <= det_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            hv_q     <= hv_d;
            head_q   <= head_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_q[AW-1:0]] <= rec_new;
    end

    assign bus.err_detect   = det_q;
    assign bus.err_count    = cnt_q;
    assign bus.log_valid    = hv_q;
    assign bus.log_exp_pc   = head_q.exp_pc;
    assign bus.log_got_pc   = head_q.got_pc;
    assign bus.log_lane     = head_q.lane;
    assign bus.log_overflow = ovf_q;
endmodule

// File: tb/tb_multi_lane_target_pc_checker.sv
// Bench for multi_lane_target_pc_checker: IALIGN=32 and IALIGN=16 instances
// fed the same stream, checked against a queue-based reference model.
module tb_multi_lane_target_pc_checker;
    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] exp_pc;
        logic [31:0] got_pc;
        int          lane;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_lane_target_pc_checker_if #(.NUM_LANES(N), .CNT_W(16)) b32 ();
    multi_lane_target_pc_checker_if #(.NUM_LANES(N), .CNT_W(4))  b16 ();

    multi_lane_target_pc_checker #(
        .NUM_LANES(N), .RESET_PC(32'h60), .IALIGN(32), .CNT_W(16), .LOG_DEPTH(DEPTH)
    ) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

    multi_lane_target_pc_checker #(
        .NUM_LANES(N), .RESET_PC(32'h60), .IALIGN(16), .CNT_W(4), .LOG_DEPTH(DEPTH)
    ) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

    logic [31:0]  s_pc [N];
    logic [31:0]  s_inst [N];
    logic [31:0]  s_rs1 [N];
    logic [31:0]  s_rs2 [N];
    logic [N-1:0] s_commit;
    logic         s_ready;

    logic [31:0] m_exp [2];
    bit          m_det [2];
    int          m_cnt [2];
    bit          m_ovf [2];
    rec_t        m_q [2][$];
    int          ia_of [2] = '{32, 16};
    int          cmax [2]  = '{65535, 15};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] ref_next(input int ia, input logic [31:0] pc,
        input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, output bit bad);
        logic signed [20:0] ji;
        logic signed [11:0] ii;
        logic signed [12:0] bi;
        logic [31:0]        ft;
        logic [31:0]        t;
        bit                 tk;
        ji = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        ii = ins[31:20];
        bi = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ft = (ia == 32 || ins[1:0] == 2'b11) ? pc + 32'd4 : pc + 32'd2;
        bad = 1'b0;
        if (ins[6:0] == 7'h6F) return pc + 32'(ji);
        if (ins[6:0] == 7'h67) begin
            t = a + 32'(ii);
            return t - (t % 32'(ia / 8));
        end
        if (ins[6:0] != 7'h63) return ft;
        case (ins[14:12])
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: begin tk = 1'b0; bad = 1'b1; end
        endcase
        return tk ? pc + 32'(bi) : ft;
    endfunction

    task automatic model_step(input int m);
        int          k;
        int          first;
        int          nmis;
        logic [31:0] e;
        bit          bad;
        rec_t        r;
        if (rst) begin
            m_exp[m] = 32'h60;
            m_det[m] = 1'b0;
            m_cnt[m] = 0;
            m_ovf[m] = 1'b0;
            m_q[m].delete();
            return;
        end
        k = 0;
        while (k < N && s_commit[k]) k++;
        if ((s_commit >> k) != 0) m_det[m] = 1'b1;
        e     = m_exp[m];
        nmis  = 0;
        first = -1;
        r     = '{32'h0, 32'h0, 0};
        for (int i = 0; i < k; i++) begin
            if (s_pc[i] != e) begin
                nmis++;
                if (first < 0) begin
                    first = i;
                    r = '{e, s_pc[i], i};
                end
            end
            e = ref_next(ia_of[m], s_pc[i], s_inst[i], s_rs1[i], s_rs2[i], bad);
            if (bad) m_det[m] = 1'b1;
        end
        m_exp[m] = e;
        if (nmis > 0) m_det[m] = 1'b1;
        m_cnt[m] = (m_cnt[m] + nmis > cmax[m]) ? cmax[m] : m_cnt[m] + nmis;
        if (s_ready && m_q[m].size() > 0) void'(m_q[m].pop_front());
        if (first >= 0) begin
            if (m_q[m].size() < DEPTH) m_q[m].push_back(r);
            else m_ovf[m] = 1'b1;
        end
    endtask

    task automatic check_dut(input int m);
        string       p;
        logic        det, vld, ovf;
        logic [31:0] cnt, lexp, lgot, lln;
        p = (m == 0) ? "i32" : "i16";
        if (m == 0) begin
            det = b32.err_detect; cnt = 32'(b32.err_count); vld = b32.log_valid;
            ovf = b32.log_overflow; lexp = b32.log_exp_pc; lgot = b32.log_got_pc;
            lln = 32'(b32.log_lane);
        end else begin
            det = b16.err_detect; cnt = 32'(b16.err_count); vld = b16.log_valid;
            ovf = b16.log_overflow; lexp = b16.log_exp_pc; lgot = b16.log_got_pc;
            lln = 32'(b16.log_lane);
        end
        chk({p, ".err_detect"}, 32'(det), 32'(m_det[m]));
        chk({p, ".err_count"}, cnt, 32'(m_cnt[m]));
        chk({p, ".log_valid"}, 32'(vld), 32'(m_q[m].size() > 0));
        chk({p, ".log_overflow"}, 32'(ovf), 32'(m_ovf[m]));
        if (m_q[m].size() > 0) begin
            chk({p, ".log_exp_pc"}, lexp, m_q[m][0].exp_pc);
            chk({p, ".log_got_pc"}, lgot, m_q[m][0].got_pc);
            chk({p, ".log_lane"}, lln, 32'(m_q[m][0].lane));
        end
    endtask

    task automatic lane(input int i, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b);
        s_pc[i] = pc; s_inst[i] = ins; s_rs1[i] = a; s_rs2[i] = b;
    endtask

    task automatic cyc(input logic [N-1:0] c, input logic r, input logic rdy);
        s_commit = c; rst = r; s_ready = rdy;
        b32.commit = c; b16.commit = c;
        b32.log_ready = rdy; b16.log_ready = rdy;
        for (int i = 0; i < N; i++) begin
            b32.pc_rdata[32*i+:32]  = s_pc[i];   b16.pc_rdata[32*i+:32]  = s_pc[i];
            b32.inst[32*i+:32]      = s_inst[i]; b16.inst[32*i+:32]      = s_inst[i];
            b32.rs1_rdata[32*i+:32] = s_rs1[i];  b16.rs1_rdata[32*i+:32] = s_rs1[i];
            b32.rs2_rdata[32*i+:32] = s_rs2[i];  b16.rs2_rdata[32*i+:32] = s_rs2[i];
        end
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        bit          bad;
        int          r;
        logic [N-1:0] c;

        for (int i = 0; i < N; i++) lane(i, 32'h0, NOP, 32'h0, 32'h0);
        cyc(2'b00, 1'b1, 1'b0);
        chk("rst_count", 32'(b32.err_count), 32'h0);
        chk("rst_valid", 32'(b32.log_valid), 32'h0);

        // single-lane sequential nops
        for (int i = 0; i < 3; i++) begin
            lane(0, 32'h60 + 32'(4 * i), NOP, 32'h0, 32'h0);
            cyc(2'b01, 1'b0, 1'b0);
        end
        chk("nop_count", 32'(b32.err_count), 32'h0);

        // taken BEQ into lane 1, then with a wrong lane-1 PC
        cyc(2'b00, 1'b1, 1'b0);
        lane(0, 32'h60, 32'h00208863, 32'd5, 32'd5);
        lane(1, 32'h70, NOP, 32'h0, 32'h0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("beq_ok_count", 32'(b32.err_count), 32'h0);
        cyc(2'b00, 1'b1, 1'b0);
        lane(1, 32'h64, NOP, 32'h0, 32'h0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("beq_bad_count", 32'(b32.err_count), 32'h1);
        chk("beq_bad_exp", b32.log_exp_pc, 32'h70);
        chk("beq_bad_got", b32.log_got_pc, 32'h64);
        chk("beq_bad_lane", 32'(b32.log_lane), 32'h1);

        // both lanes wrong, then resync from lane-1 PC
        lane(0, 32'h100, NOP, 32'h0, 32'h0);
        lane(1, 32'h200, NOP, 32'h0, 32'h0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("dual_count", 32'(b32.err_count), 32'h3);
        lane(0, 32'h204, NOP, 32'h0, 32'h0);
        cyc(2'b01, 1'b0, 1'b0);
        chk("resync_count", 32'(b32.err_count), 32'h3);

        // JALR target wraps past 2^32
        cyc(2'b00, 1'b1, 1'b0);
        lane(0, 32'h60, {12'd3, 5'd1, 3'b000, 5'd0, 7'b1100111}, 32'hFFFFFFFF, 32'h0);
        lane(1, 32'h0, NOP, 32'h0, 32'h0);
        cyc(2'b11, 1'b0, 1'b0);
        chk("jalr_wrap_count", 32'(b32.err_count), 32'h0);

        // overflow: five errors with no consumer
        cyc(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            lane(0, 32'h1000 + 32'(16 * i), NOP, 32'h0, 32'h0);
            cyc(2'b01, 1'b0, 1'b0);
        end
        chk("ovf_flag", 32'(b32.log_overflow), 32'h1);
        chk("ovf_oldest", b32.log_exp_pc, 32'h60);

        // full FIFO with simultaneous push and pop
        cyc(2'b00, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            lane(0, 32'h2000 + 32'(16 * i), NOP, 32'h0, 32'h0);
            cyc(2'b01, 1'b0, 1'b0);
        end
        lane(0, 32'h3000, NOP, 32'h0, 32'h0);
        cyc(2'b01, 1'b0, 1'b1);
        chk("pushpop_ovf", 32'(b32.log_overflow), 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(2'b00, 1'b0, 1'b1);
        chk("drained", 32'(b32.log_valid), 32'h0);

        // lane gap, then mid-stream reset
        cyc(2'b00, 1'b1, 1'b0);
        lane(0, 32'h60, NOP, 32'h0, 32'h0);
        lane(1, 32'h64, NOP, 32'h0, 32'h0);
        cyc(2'b10, 1'b0, 1'b0);
        chk("gap_detect", 32'(b32.err_detect), 32'h1);
        lane(0, 32'h999, NOP, 32'h0, 32'h0);
        cyc(2'b11, 1'b1, 1'b1);
        chk("midrst_detect", 32'(b32.err_detect), 32'h0);
        lane(0, 32'h60, NOP, 32'h0, 32'h0);
        cyc(2'b01, 1'b0, 1'b0);
        chk("postrst_count", 32'(b32.err_count), 32'h0);

        // randomized stream
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            c = (r < 10) ? 2'b00 : (r < 40) ? 2'b01 : (r < 98) ? 2'b11 : 2'b10;
            e = m_exp[0];
            for (int i = 0; i < N; i++) begin
                ins = $urandom;
                case ($urandom_range(0, 4))
                    0: ins[6:0] = 7'h6F;
                    1: ins[6:0] = 7'h67;
                    2: begin
                        ins[6:0] = 7'h63;
                        if ($urandom_range(0, 9) != 0) begin
                            r = $urandom_range(0, 5);
                            ins[14:12] = 3'((r < 2) ? r : r + 2);
                        end
                    end
                    default: ;
                endcase
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                if ($urandom_range(0, 7) == 0) e = e ^ (32'($urandom_range(1, 15)) << 1);
                lane(i, e, ins, a, b);
                e = ref_next(32, e, ins, a, b, bad);
            end
            cyc(c, $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
